// File: rtl/fifo_to_wmst_tile_pkg.sv
// Shared definitions for the store tile: FSM encoding, word size and burst sizing helper.
package fifo_to_wmst_tile_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StIssue = 3'd1;
   localparam state_t StData  = 3'd2;
   localparam state_t StWait  = 3'd3;
   localparam state_t StDone  = 3'd4;

   localparam int unsigned BytesPerWord = 4;

   function automatic int unsigned min_words(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fifo_to_wmst_tile_if.sv
// Store-FIFO, tile-control and Avalon write-master signals of the store tile.
interface fifo_to_wmst_tile_if #(
   parameter int unsigned AW  = 12,
   parameter int unsigned CW  = 6,
   parameter int unsigned DW  = 32,
   parameter int unsigned XAW = 32,
   parameter int unsigned XDW = 128
);
   logic           store_start;
   logic [XAW-1:0] param_waddr;
   logic [AW-1:0]  param_iolen;
   logic           store_done;

   logic           store_fifo_pop;
   logic [DW-1:0]  store_fifo_data;
   logic           store_fifo_empty;

   logic           wmst_fixed_location;
   logic [XAW-1:0] wmst_write_base;
   logic [CW-1:0]  wmst_write_length;
   logic           wmst_go;
   logic           wmst_done;
   logic           wmst_user_write_buffer;
   logic [XDW-1:0] wmst_user_buffer_data;
   logic           wmst_user_buffer_full;

   modport master (
      input  store_start, param_waddr, param_iolen, store_fifo_data, store_fifo_empty,
             wmst_done, wmst_user_buffer_full,
      output store_done, store_fifo_pop, wmst_fixed_location, wmst_write_base,
             wmst_write_length, wmst_go, wmst_user_write_buffer, wmst_user_buffer_data
   );

   modport slave (
      output store_start, param_waddr, param_iolen, store_fifo_data, store_fifo_empty,
             wmst_done, wmst_user_buffer_full,
      input  store_done, store_fifo_pop, wmst_fixed_location, wmst_write_base,
             wmst_write_length, wmst_go, wmst_user_write_buffer, wmst_user_buffer_data
   );

endinterface

// File: rtl/fifo_to_wmst_tile_word_packer.sv
// Packs DW-bit FIFO words into XDW-bit beats (first word in the lowest lane) and
// presents them to the write master with a stall-safe output register.
module fifo_to_wmst_tile_word_packer #(
   parameter int unsigned AW  = 12,
   parameter int unsigned DW  = 32,
   parameter int unsigned XDW = 128
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [AW-1:0]  load_words,
   input  logic           fifo_empty,
   input  logic [DW-1:0]  fifo_data,
   output logic           fifo_pop,
   input  logic           buffer_full,
   output logic           write_buffer,
   output logic [XDW-1:0] buffer_data,
   output logic           burst_end
);

   localparam int unsigned WCNT = XDW / DW;
   localparam int unsigned LW   = $clog2(WCNT + 1);

   // cnt_q counts words popped into the current assembly, including one still in flight.
   logic [LW-1:0]  cnt_q, cnt_d;
   logic [LW-1:0]  rd_lane_q, rd_lane_d;
   logic           rd_pend_q, rd_pend_d;
   logic [XDW-1:0] asm_q, asm_d;
   logic [XDW-1:0] out_q, out_d;
   logic           out_valid_q, out_valid_d;
   logic [AW-1:0]  pop_left_q, pop_left_d;
   logic [AW-1:0]  beat_left_q, beat_left_d;

   logic asm_full;
   logic move;
   logic pop;
   logic write;

   assign asm_full = (cnt_q == LW'(WCNT));
   assign write    = out_valid_q && !buffer_full;
   assign pop      = !fifo_empty && (pop_left_q != '0) && !asm_full && (!out_valid_q || write);
   // A complete beat may only move once its last word has actually landed.
   assign move     = asm_full && !rd_pend_q && (!out_valid_q || write);

   always_comb begin
      asm_d       = asm_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      pop_left_d  = pop_left_q;
      beat_left_d = beat_left_q;
      rd_pend_d   = pop;
      rd_lane_d   = cnt_q;

      if (rd_pend_q) begin
         asm_d[DW*rd_lane_q +: DW] = fifo_data;
      end

      if (move) begin
         out_d       = asm_q;
         out_valid_d = 1'b1;
         cnt_d       = '0;
      end else begin
         if (write) begin
            out_valid_d = 1'b0;
         end
         if (pop) begin
            cnt_d = cnt_q + LW'(1);
         end
      end

      if (load) begin
         pop_left_d  = load_words;
         beat_left_d = AW'(load_words / AW'(WCNT));
      end else begin
         if (pop) begin
            pop_left_d = pop_left_q - AW'(1);
         end
         if (write && (beat_left_q != '0)) begin
            beat_left_d = beat_left_q - AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         rd_lane_q   <= '0;
         rd_pend_q   <= 1'b0;
         asm_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         pop_left_q  <= '0;
         beat_left_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         rd_lane_q   <= rd_lane_d;
         rd_pend_q   <= rd_pend_d;
         asm_q       <= asm_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         pop_left_q  <= pop_left_d;
         beat_left_q <= beat_left_d;
      end
   end

   assign fifo_pop     = pop;
   assign write_buffer = write;
   assign buffer_data  = out_q;
   assign burst_end    = write && (beat_left_q == AW'(1));

endmodule

// File: rtl/fifo_to_wmst_tile.sv
// Store tile: drains a tile from the store FIFO and writes it to external memory as a
// sequence of write-master bursts of up to BLEN words.
module fifo_to_wmst_tile
   import fifo_to_wmst_tile_pkg::*;
#(
   parameter int unsigned AW   = 12,
   parameter int unsigned CW   = 6,
   parameter int unsigned DW   = 32,
   parameter int unsigned XAW  = 32,
   parameter int unsigned XDW  = 128,
   parameter int unsigned BLEN = 8
) (
   input logic                clk,
   input logic                rst,
   fifo_to_wmst_tile_if.master bus
);

   state_t         state_q, state_d;
   logic [XAW-1:0] addr_q, addr_d;
   logic [AW-1:0]  rem_q, rem_d;
   logic [AW-1:0]  burst_q, burst_d;
   logic [XAW-1:0] base_q, base_d;
   logic [CW-1:0]  len_q, len_d;
   logic           go_q, go_d;
   logic           done_q, done_d;

   logic [AW-1:0]  burst_w;
   logic           load;
   logic           burst_end;

   assign burst_w = AW'(min_words(32'(rem_q), BLEN));
   assign load    = (state_q == StIssue) && bus.wmst_done;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      burst_d = burst_q;
      base_d  = base_q;
      len_d   = len_q;
      go_d    = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.store_start) begin
               addr_d  = bus.param_waddr;
               rem_d   = bus.param_iolen;
               state_d = (bus.param_iolen == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            if (bus.wmst_done) begin
               go_d    = 1'b1;
               base_d  = addr_q;
               len_d   = CW'(32'(burst_w) * BytesPerWord);
               burst_d = burst_w;
               state_d = StData;
            end
         end
         StData: begin
            if (burst_end) begin
               addr_d  = addr_q + XAW'(32'(burst_q) * BytesPerWord);
               rem_d   = (rem_q > burst_q) ? (rem_q - burst_q) : '0;
               state_d = StWait;
            end
         end
         StWait: begin
            // ISSUE re-checks wmst_done, so a single settling cycle is enough here.
            state_d = (rem_q != '0) ? StIssue : StDone;
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         burst_q <= '0;
         base_q  <= '0;
         len_q   <= '0;
         go_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         burst_q <= burst_d;
         base_q  <= base_d;
         len_q   <= len_d;
         go_q    <= go_d;
         done_q  <= done_d;
      end
   end

   fifo_to_wmst_tile_word_packer #(
      .AW  (AW),
      .DW  (DW),
      .XDW (XDW)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_words   (burst_w),
      .fifo_empty   (bus.store_fifo_empty),
      .fifo_data    (bus.store_fifo_data),
      .fifo_pop     (bus.store_fifo_pop),
      .buffer_full  (bus.wmst_user_buffer_full),
      .write_buffer (bus.wmst_user_write_buffer),
      .buffer_data  (bus.wmst_user_buffer_data),
      .burst_end    (burst_end)
   );

   assign bus.store_done          = done_q;
   assign bus.wmst_fixed_location = 1'b0;
   assign bus.wmst_write_base     = base_q;
   assign bus.wmst_write_length   = len_q;
   assign bus.wmst_go             = go_q;

endmodule

// File: tb/tb_fifo_to_wmst_tile.sv
// Randomised bench for fifo_to_wmst_tile: FIFO and write-master models plus a tile-level
// reference of the expected bursts and beats.
module tb_fifo_to_wmst_tile;

   localparam int unsigned AW = 12, CW = 6, DW = 32, XAW = 32, XDW = 128, BLEN = 8;
   localparam int unsigned WCNT = XDW / DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_to_wmst_tile_if #(.AW(AW), .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW)) bus ();

   fifo_to_wmst_tile #(
      .AW(AW), .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW), .BLEN(BLEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_miss = 0;

   int cyc = 0;
   int done_cnt, done_cyc, go_cyc, start_cyc, pop_cnt;
   int stall_pops, stall_wr, unstable, underflow, stall_hist;
   int stall_req = 0;
   bit toggle_empty = 0, rand_empty = 0, rand_full = 0, stall_on = 0;
   logic [37:0]  go_q[$];
   logic [127:0] beat_q[$];
   logic [31:0]  fifo_q[$];
   logic [31:0]  words[$];
   logic [37:0]  exp_go[$];
   logic [127:0] exp_beats[$];

   // FIFO, write-master and recorder; samples DUT outputs on the falling edge.
   initial begin : env
      bit s_pop, s_wr, s_go, s_rst, busy;
      logic [CW-1:0] s_len;
      logic [127:0] prev_data;
      int beats_rem, dly;
      busy = 0; beats_rem = 0; dly = 0; prev_data = '0;
      bus.store_fifo_data = '0;
      bus.store_fifo_empty = 1'b1;
      bus.wmst_done = 1'b1;
      bus.wmst_user_buffer_full = 1'b0;
      forever begin
         @(negedge clk);
         s_rst = rst;
         s_pop = bus.store_fifo_pop;
         s_wr  = bus.wmst_user_write_buffer;
         s_go  = bus.wmst_go;
         s_len = bus.wmst_write_length;
         if (bus.store_done) begin done_cnt++; done_cyc = cyc; end
         if (s_go) begin
            go_q.push_back({bus.wmst_write_base, bus.wmst_write_length});
            if (go_cyc < 0) go_cyc = cyc;
         end
         if (s_wr) beat_q.push_back(bus.wmst_user_buffer_data);
         if (s_pop) pop_cnt++;
         if (stall_on && bus.wmst_user_buffer_full) begin
            if (s_pop) stall_pops++;
            if (s_wr) stall_wr++;
            if (stall_hist >= 8 && bus.wmst_user_buffer_data !== prev_data) unstable++;
            stall_hist++;
         end else begin
            stall_hist = 0;
         end
         prev_data = bus.wmst_user_buffer_data;

         @(posedge clk);
         cyc++;
         #1;
         if (s_pop) begin
            if (fifo_q.size() == 0) underflow++;
            else bus.store_fifo_data = fifo_q.pop_front();
         end
         if (s_rst) begin
            busy = 0; dly = 0; beats_rem = 0;
            bus.wmst_done = 1'b1;
         end else begin
            if (s_go) begin
               busy = 1;
               beats_rem = int'(s_len) / (4 * WCNT);
               bus.wmst_done = 1'b0;
            end
            if (s_wr && busy && beats_rem > 0) begin
               beats_rem--;
               if (beats_rem == 0) dly = 2;
            end else if (dly > 0) begin
               dly--;
               if (dly == 0) begin busy = 0; bus.wmst_done = 1'b1; end
            end
         end
         stall_on = 0;
         if (stall_req > 0) begin
            bus.wmst_user_buffer_full = 1'b1;
            stall_on = 1;
            stall_req--;
         end else begin
            bus.wmst_user_buffer_full = rand_full && ($urandom_range(0, 3) == 0);
         end
         bus.store_fifo_empty = (fifo_q.size() == 0) || (toggle_empty && cyc[0]) ||
                                (rand_empty && ($urandom_range(0, 2) == 0));
      end
   end

   task automatic clear_rec();
      go_q.delete(); beat_q.delete();
      done_cnt = 0; done_cyc = -1; go_cyc = -1; pop_cnt = 0;
      stall_pops = 0; stall_wr = 0; unstable = 0; underflow = 0;
   endtask

   task automatic load_words(input int n, input bit rnd);
      words.delete(); fifo_q.delete();
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = rnd ? $urandom : 32'(i);
         words.push_back(w);
         fifo_q.push_back(w);
      end
   endtask

   // Reference: bursts of min(remaining, BLEN) words, beats packed lowest word first.
   task automatic build_exp(input logic [31:0] addr, input int len);
      exp_go.delete(); exp_beats.delete();
      for (int off = 0; off < len; off += BLEN) begin
         int n;
         n = (len - off < BLEN) ? len - off : BLEN;
         exp_go.push_back({addr + 32'(off * 4), 6'(n * 4)});
      end
      for (int b = 0; b < len / WCNT; b++) begin
         logic [127:0] beat;
         beat = '0;
         for (int k = 0; k < WCNT; k++) beat[32*k +: 32] = words[b*WCNT + k];
         exp_beats.push_back(beat);
      end
   endtask

   task automatic run_tile(input logic [31:0] addr, input int len, output bit ok);
      @(posedge clk); #1;
      bus.param_waddr = addr;
      bus.param_iolen = 12'(len);
      bus.store_start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      bus.store_start = 1'b0;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (done_cnt > 0) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   int lat_pre;

   task automatic test_reset();
      rst = 1'b1;
      bus.store_start = 1'b0; bus.param_waddr = '0; bus.param_iolen = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.store_fifo_pop, bus.wmst_user_write_buffer, bus.wmst_go, bus.store_done,
           bus.wmst_fixed_location} !== 5'b0) begin
         n_miss++;
         $display("FAIL reset_ctrl: got %b want 00000", {bus.store_fifo_pop,
                  bus.wmst_user_write_buffer, bus.wmst_go, bus.store_done, bus.wmst_fixed_location});
      end
      n_vec++;
      if (bus.wmst_write_base !== '0 || bus.wmst_write_length !== '0) begin
         n_miss++;
         $display("FAIL reset_regs: base %h len %0d want 0/0", bus.wmst_write_base,
                  bus.wmst_write_length);
      end
      n_vec++;
      if (bus.wmst_user_buffer_data !== '0) begin
         n_miss++;
         $display("FAIL reset_data: got %h want 0", bus.wmst_user_buffer_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_preload();
      bit ok;
      clear_rec(); load_words(16, 0); build_exp(32'h1000, 16);
      run_tile(32'h1000, 16, ok);
      lat_pre = done_cyc - start_cyc;
      n_vec++;
      if (!ok) begin n_miss++; $display("FAIL preload_timeout: no store_done"); end
      n_vec++;
      if (go_cyc - start_cyc != 2) begin
         n_miss++; $display("FAIL preload_go_latency: got %0d want 2", go_cyc - start_cyc);
      end
      n_vec++;
      if (beat_q.size() < 1 || beat_q[0] !== 128'h00000003_00000002_00000001_00000000) begin
         n_miss++; $display("FAIL preload_first_beat: got %p", beat_q);
      end
      n_vec++;
      if (go_q.size() != exp_go.size() || beat_q.size() != exp_beats.size() || done_cnt != 1) begin
         n_miss++;
         $display("FAIL preload_counts: go %0d/%0d beats %0d/%0d done %0d/1", go_q.size(),
                  exp_go.size(), beat_q.size(), exp_beats.size(), done_cnt);
      end
      foreach (exp_go[i]) if (i < go_q.size()) begin
         n_vec++;
         if (go_q[i] !== exp_go[i]) begin
            n_miss++; $display("FAIL preload_go[%0d]: got %h want %h", i, go_q[i], exp_go[i]);
         end
      end
      foreach (exp_beats[i]) if (i < beat_q.size()) begin
         n_vec++;
         if (beat_q[i] !== exp_beats[i]) begin
            n_miss++;
            $display("FAIL preload_beat[%0d]: got %h want %h", i, beat_q[i], exp_beats[i]);
         end
      end
   endtask

   task automatic test_short_burst();
      bit ok;
      clear_rec(); load_words(12, 1); build_exp(32'h1000, 12);
      run_tile(32'h1000, 12, ok);
      n_vec++;
      if (!ok || go_q.size() != 2 || beat_q.size() != 3 || done_cnt != 1) begin
         n_miss++;
         $display("FAIL short_counts: ok %0d go %0d/2 beats %0d/3 done %0d/1", ok, go_q.size(),
                  beat_q.size(), done_cnt);
      end
      foreach (exp_go[i]) if (i < go_q.size()) begin
         n_vec++;
         if (go_q[i] !== exp_go[i]) begin
            n_miss++; $display("FAIL short_go[%0d]: got %h want %h", i, go_q[i], exp_go[i]);
         end
      end
      foreach (exp_beats[i]) if (i < beat_q.size()) begin
         n_vec++;
         if (beat_q[i] !== exp_beats[i]) begin
            n_miss++; $display("FAIL short_beat[%0d]: got %h want %h", i, beat_q[i], exp_beats[i]);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      clear_rec(); load_words(16, 0); build_exp(32'h1000, 16);
      @(posedge clk); #1;
      bus.param_waddr = 32'h1000; bus.param_iolen = 12'd16; bus.store_start = 1'b1;
      @(posedge clk); #1;
      bus.store_start = 1'b0;
      for (int i = 0; i < 200 && beat_q.size() == 0; i++) begin @(posedge clk); #1; end
      stall_req = 10;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (done_cnt > 0) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      n_vec++;
      if (!ok) begin n_miss++; $display("FAIL stall_timeout: no store_done"); end
      n_vec++;
      if (stall_wr != 0 || unstable != 0) begin
         n_miss++; $display("FAIL stall_hold: writes %0d changes %0d want 0/0", stall_wr, unstable);
      end
      n_vec++;
      if (stall_pops > WCNT) begin
         n_miss++; $display("FAIL stall_pops: got %0d want <= %0d", stall_pops, WCNT);
      end
      n_vec++;
      if (beat_q.size() != exp_beats.size() || pop_cnt != 16 || underflow != 0) begin
         n_miss++;
         $display("FAIL stall_counts: beats %0d/4 pops %0d/16 underflow %0d", beat_q.size(),
                  pop_cnt, underflow);
      end
      foreach (exp_beats[i]) if (i < beat_q.size()) begin
         n_vec++;
         if (beat_q[i] !== exp_beats[i]) begin
            n_miss++; $display("FAIL stall_beat[%0d]: got %h want %h", i, beat_q[i], exp_beats[i]);
         end
      end
   endtask

   task automatic test_empty_toggle();
      bit ok;
      clear_rec(); load_words(16, 0); build_exp(32'h1000, 16);
      toggle_empty = 1;
      run_tile(32'h1000, 16, ok);
      toggle_empty = 0;
      n_vec++;
      if (!ok || beat_q.size() != exp_beats.size() || go_q.size() != exp_go.size()) begin
         n_miss++;
         $display("FAIL toggle_counts: ok %0d beats %0d go %0d", ok, beat_q.size(), go_q.size());
      end
      n_vec++;
      if (done_cyc - start_cyc <= lat_pre) begin
         n_miss++;
         $display("FAIL toggle_latency: got %0d want > %0d", done_cyc - start_cyc, lat_pre);
      end
      foreach (exp_beats[i]) if (i < beat_q.size()) begin
         n_vec++;
         if (beat_q[i] !== exp_beats[i]) begin
            n_miss++;
            $display("FAIL toggle_beat[%0d]: got %h want %h", i, beat_q[i], exp_beats[i]);
         end
      end
   endtask

   task automatic test_zero_len();
      bit ok;
      clear_rec(); load_words(4, 1);
      run_tile(32'h3000, 0, ok);
      n_vec++;
      if (!ok || done_cnt != 1 || done_cyc - start_cyc != 2) begin
         n_miss++;
         $display("FAIL zero_done: count %0d latency %0d want 1/2", done_cnt, done_cyc - start_cyc);
      end
      n_vec++;
      if (go_q.size() != 0 || pop_cnt != 0) begin
         n_miss++; $display("FAIL zero_activity: go %0d pops %0d want 0/0", go_q.size(), pop_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_rec(); load_words(16, 1);
      @(posedge clk); #1;
      bus.param_waddr = 32'h1000; bus.param_iolen = 12'd16; bus.store_start = 1'b1;
      @(posedge clk); #1;
      bus.store_start = 1'b0;
      for (int i = 0; i < 200 && pop_cnt < 5; i++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({bus.store_fifo_pop, bus.wmst_user_write_buffer, bus.wmst_go, bus.store_done} !== 4'b0 ||
          bus.wmst_write_base !== '0 || bus.wmst_write_length !== '0 ||
          bus.wmst_user_buffer_data !== '0) begin
         n_miss++;
         $display("FAIL midrst_outputs: ctrl %b base %h len %0d want all 0", {bus.store_fifo_pop,
                  bus.wmst_user_write_buffer, bus.wmst_go, bus.store_done}, bus.wmst_write_base,
                  bus.wmst_write_length);
      end
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      n_vec++;
      if (done_cnt != 0) begin
         n_miss++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt);
      end
      clear_rec(); load_words(8, 1); build_exp(32'h2000, 8);
      run_tile(32'h2000, 8, ok);
      n_vec++;
      if (!ok || done_cnt != 1 || go_q.size() != 1 || beat_q.size() != 2) begin
         n_miss++;
         $display("FAIL midrst_rerun: ok %0d done %0d go %0d beats %0d", ok, done_cnt,
                  go_q.size(), beat_q.size());
      end
      if (go_q.size() > 0) begin
         n_vec++;
         if (go_q[0] !== exp_go[0]) begin
            n_miss++; $display("FAIL midrst_go: got %h want %h", go_q[0], exp_go[0]);
         end
      end
      foreach (exp_beats[i]) if (i < beat_q.size()) begin
         n_vec++;
         if (beat_q[i] !== exp_beats[i]) begin
            n_miss++; $display("FAIL midrst_beat[%0d]: got %h want %h", i, beat_q[i], exp_beats[i]);
         end
      end
   endtask

   task automatic test_random();
      rand_empty = 1; rand_full = 1;
      for (int it = 0; it < 8; it++) begin
         bit ok;
         int len;
         logic [31:0] addr;
         len  = 4 * $urandom_range(1, 12);
         addr = (it == 0) ? 32'hFFFF_FFE0 : {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
         if (it == 0) len = 16;
         clear_rec(); load_words(len, 1); build_exp(addr, len);
         run_tile(addr, len, ok);
         n_vec++;
         if (!ok || done_cnt != 1 || go_q.size() != exp_go.size() ||
             beat_q.size() != exp_beats.size() || underflow != 0) begin
            n_miss++;
            $display("FAIL rand%0d_counts: ok %0d done %0d go %0d/%0d beats %0d/%0d", it, ok,
                     done_cnt, go_q.size(), exp_go.size(), beat_q.size(), exp_beats.size());
         end
         foreach (exp_go[i]) if (i < go_q.size()) begin
            n_vec++;
            if (go_q[i] !== exp_go[i]) begin
               n_miss++; $display("FAIL rand%0d_go[%0d]: got %h want %h", it, i, go_q[i], exp_go[i]);
            end
         end
         foreach (exp_beats[i]) if (i < beat_q.size()) begin
            n_vec++;
            if (beat_q[i] !== exp_beats[i]) begin
               n_miss++;
               $display("FAIL rand%0d_beat[%0d]: got %h want %h", it, i, beat_q[i], exp_beats[i]);
            end
         end
      end
      rand_empty = 0; rand_full = 0;
   endtask

   initial begin
      clear_rec();
      test_reset();
      test_preload();
      test_short_burst();
      test_stall();
      test_empty_toggle();
      test_zero_len();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
